// File: rtl/axi4_selfcheck_master.sv
// AXI4 master traffic generator/checker: one INCR write burst of a seeded
// pattern, one INCR read burst of the same region, every read beat compared.
module axi4_selfcheck_master #(
  parameter int unsigned G_ADDR_WIDTH = 32,
  parameter int unsigned G_DATA_WIDTH = 512,
  parameter int unsigned G_ID_WIDTH   = 50,
  parameter int unsigned G_ID_VALUE   = 0,
  parameter int unsigned G_TIMEOUT    = 1024
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [G_ADDR_WIDTH-1:0]   base_addr,
  input  logic [7:0]                burst_len,
  input  logic [31:0]               seed,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [15:0]               error_count,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [G_ID_WIDTH-1:0]     m_axi_awid,
  output logic [G_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic                      m_axi_awlock,
  output logic [3:0]                m_axi_awcache,
  output logic [2:0]                m_axi_awprot,
  output logic [3:0]                m_axi_awqos,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  output logic [G_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [G_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                      m_axi_wlast,
  output logic                      m_axi_bready,
  input  logic                      m_axi_bvalid,
  input  logic [G_ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]                m_axi_bresp,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  output logic [G_ID_WIDTH-1:0]     m_axi_arid,
  output logic [G_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic                      m_axi_arlock,
  output logic [3:0]                m_axi_arcache,
  output logic [2:0]                m_axi_arprot,
  output logic [3:0]                m_axi_arqos,
  output logic                      m_axi_rready,
  input  logic                      m_axi_rvalid,
  input  logic [G_ID_WIDTH-1:0]     m_axi_rid,
  input  logic [G_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast
);

  localparam int unsigned LANES  = G_DATA_WIDTH / 32;
  localparam int unsigned STRB_W = G_DATA_WIDTH / 8;
  localparam int unsigned SIZE   = $clog2(STRB_W);
  localparam int unsigned WD_W   = $clog2(G_TIMEOUT + 1);
  localparam logic [WD_W-1:0]         WD_LAST = WD_W'(G_TIMEOUT - 1);
  localparam logic [G_ID_WIDTH-1:0]   ID_VAL  = G_ID_WIDTH'(G_ID_VALUE);
  localparam logic [G_ADDR_WIDTH-1:0] LSB_MASK = G_ADDR_WIDTH'(STRB_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

  state_t                  state, state_nx;
  logic [G_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]              len_q;
  logic [7:0]              beat_q;
  logic [31:0]             seed_q;
  logic [WD_W-1:0]         wdog_q;
  logic [15:0]             err_q;
  logic                    pass_q;
  logic                    timeout_q;

  logic                    hs;
  logic                    waiting;
  logic                    wd_expire;
  logic                    last_beat;
  logic                    pass_now;
  logic [2:0]              err_inc;
  logic [16:0]             err_sum;
  logic [15:0]             err_nx;
  logic [31:0]             pat_word;
  logic [G_DATA_WIDTH-1:0] pattern;

  assign pat_word  = seed_q + 32'(beat_q);
  assign pattern   = {LANES{pat_word}};
  assign last_beat = (beat_q == len_q);

  assign hs = (m_axi_awvalid && m_axi_awready) || (m_axi_wvalid && m_axi_wready) ||
              (m_axi_bready && m_axi_bvalid)   || (m_axi_arvalid && m_axi_arready) ||
              (m_axi_rready && m_axi_rvalid);
  assign waiting   = (state inside {S_AW, S_W, S_B, S_AR, S_R});
  assign wd_expire = waiting && !hs && (wdog_q == WD_LAST);

  // Up to four independent checks can fail on one read beat.
  always_comb begin
    err_inc = '0;
    if (state == S_B && m_axi_bvalid)
      err_inc = 3'((m_axi_bresp != 2'b00) || (m_axi_bid != ID_VAL));
    else if (state == S_R && m_axi_rvalid)
      err_inc = 3'(m_axi_rdata != pattern) + 3'(m_axi_rresp != 2'b00) +
                3'(m_axi_rid != ID_VAL) + 3'(m_axi_rlast != last_beat);
  end

  assign err_sum = {1'b0, err_q} + 17'(err_inc);
  assign err_nx  = err_sum[16] ? 16'hFFFF : err_sum[15:0];

  always_comb begin
    state_nx      = state;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    unique case (state)
      S_IDLE: if (start) state_nx = S_AW;
      S_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_nx = S_W;
      end
      S_W: begin
        m_axi_wvalid = 1'b1;
        if (m_axi_wready && last_beat) state_nx = S_B;
      end
      S_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_nx = S_AR;
      end
      S_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nx = S_R;
      end
      S_R: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid && last_beat) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (wd_expire) state_nx = S_DONE;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      seed_q    <= '0;
      beat_q    <= '0;
      wdog_q    <= '0;
      err_q     <= '0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= err_nx;
      wdog_q <= (waiting && !hs) ? wdog_q + 1'b1 : '0;
      if (wd_expire) timeout_q <= 1'b1;
      unique case (state)
        S_IDLE: if (start) begin
          addr_q    <= base_addr & ~LSB_MASK;
          len_q     <= burst_len;
          seed_q    <= seed;
          beat_q    <= '0;
          err_q     <= '0;
          pass_q    <= 1'b0;
          timeout_q <= 1'b0;
        end
        // The beat counter is reused for the read pass, so it wraps to 0 after the last write.
        S_W:    if (m_axi_wready) beat_q <= last_beat ? '0 : beat_q + 1'b1;
        S_R:    if (m_axi_rvalid) beat_q <= beat_q + 1'b1;
        S_DONE: pass_q <= pass_now;
        default: ;
      endcase
    end
  end

  assign pass_now    = (err_q == '0) && !timeout_q;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign pass        = done ? pass_now : pass_q;
  assign timeout     = timeout_q;
  assign error_count = err_q;

  assign m_axi_awid    = ID_VAL;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = '0;
  assign m_axi_awqos   = '0;

  assign m_axi_wdata = pattern;
  assign m_axi_wstrb = '1;
  assign m_axi_wlast = (state == S_W) && last_beat;

  assign m_axi_arid    = ID_VAL;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = '0;
  assign m_axi_arqos   = '0;

endmodule

// File: doc/axi4_selfcheck_master.md
Name: axi4_selfcheck_master

Overview:
AXI4 full master traffic generator and checker for simulation benches and integration tests. It drives the slave side of the bench memory (axi4_full_slave) in place of the GPU. On each start it issues one INCR write burst of a seeded pattern, then one INCR read burst of the same region, and compares every returned beat. It reports pass/fail and an error count, so the bench FSM can sequence runs and call $finish.

Parameters:
G_ADDR_WIDTH, 32, AXI address width
G_DATA_WIDTH, 512, AXI data width; must be a multiple of 32
G_ID_WIDTH, 50, AXI ID width
G_ID_VALUE, 0, ID driven on awid/arid and expected on bid/rid
G_TIMEOUT, 1024, maximum cycles spent waiting in any one handshake state

Ports:
clock  input  1  sole clock, rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  pulse; accepted only in IDLE
base_addr  input  G_ADDR_WIDTH  burst start byte address, sampled on start
burst_len  input  8  AXI len; beats = burst_len+1, sampled on start
seed  input  32  pattern seed, sampled on start
busy  output  1  high from accepted start until DONE is left
done  output  1  one-cycle pulse when a run completes
pass  output  1  result of the last run, held until the next start
timeout  output  1  last run aborted by the watchdog, held until the next start
error_count  output  16  saturating mismatch/response error count for the last run
m_axi_aw{valid,id,addr,len,size,burst} / awready  out/in  AXI widths  write address channel
m_axi_aw{lock,cache,prot,qos}  output  1/4/3/4  constants 0, 4'b0011, 0, 0 (same on ar channel)
m_axi_w{valid,data,strb,last} / wready  out/in  AXI widths  write data channel
m_axi_b{ready} / bvalid,bid,bresp  out/in  1,1,G_ID_WIDTH,2  write response channel
m_axi_ar{valid,id,addr,len,size,burst} / arready  out/in  AXI widths  read address channel
m_axi_r{ready} / rvalid,rid,rdata,rresp,rlast  out/in  AXI widths  read data channel

Behaviour:
- Reset (asynchronous, immediate): state IDLE; all valid/ready outputs 0; busy, done, pass, timeout 0; error_count 0; the beat counter and watchdog are cleared. Reset mid-burst abandons the transaction with no drain.
- FSM states: IDLE -> AW -> W -> B -> AR -> R -> DONE -> IDLE.
- IDLE: start=1 latches the inputs; the low log2(G_DATA_WIDTH/8) bits of the address are forced to 0; error_count, pass and timeout are cleared. Next cycle the FSM is in AW with busy=1. start in any other state is ignored.
- AW/AR: valid rises on state entry and holds, with stable payload, until valid&&ready, then advances. burst=2'b01 (INCR), size=log2(G_DATA_WIDTH/8), len=latched burst_len.
- W: the first beat is valid the cycle after the AW handshake. Beat i (0-based) data = G_DATA_WIDTH/32 copies of (seed+i) mod 2^32. strb is all ones. wlast=1 only on beat burst_len. A beat advances only on wvalid&&wready; wvalid stays high between beats (no bubbles). After the last handshake -> B.
- B: bready=1. On bvalid: if bresp!=0 or bid!=G_ID_VALUE, error_count+1. Then -> AR.
- R: rready=1. On each rvalid beat i, each of these checks adds 1 to error_count: rdata mismatch vs the beat-i pattern, rresp!=0, rid!=G_ID_VALUE, and rlast!=(i==burst_len). The FSM leaves R on the burst_len-th beat even if rlast is absent. An early rlast counts as an error and does not end the burst.
- error_count saturates at 16'hFFFF.
- Watchdog: counts cycles in AW, W, B, AR and R without a handshake, and resets on every handshake. Reaching G_TIMEOUT sets timeout=1, drops all valid/ready signals and goes to DONE.
- DONE: done=1 for one cycle; pass=(error_count==0 && !timeout). Next cycle busy=0 and state is IDLE.
- 4 KB boundary crossings are not split; the caller chooses base_addr and burst_len.
- Minimum run latency with zero-wait slave = 1 (AW) + (len+1) (W) + 1 (B) + 1 (AR) + (len+1) (R) + 1 (DONE) cycles.

Test Plan:
- Zero-wait against axi4_full_slave (G_ADDR_WIDTH=10), base 0x000, len 0, seed 0x12345678 -> one W beat of 16 copies of 0x12345678, done after 6 cycles, pass=1, error_count=0.
- base 0x040, len 3, seed 0xFFFFFFFE -> beat data 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001 (wrap); wlast only on beat 3; pass=1.
- Bench slave with random ready stalls and one rdata bit flipped on beat 2 of len 7 -> valid/payload stable under stall, error_count=1, pass=0.
- bresp=2'b10 and an early rlast on beat 0 of len 1 -> error_count=2, pass=0.
- awready tied 0, G_TIMEOUT=16 -> timeout=1 at cycle 17 after start, awvalid drops, done pulses, pass=0; start during busy is ignored.
- resetn asserted mid-W -> all valids 0 immediately; a new start after reset completes with pass=1.
